// File: rtl/haze_pkg.sv
// Shared types and constants for the haze-removal output streaming path.
package haze_pkg;

   localparam int PIXEL_W = 24;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

endpackage

// File: rtl/haze_sync_fifo.sv
// Single-clock FIFO with pointer-difference level; a write into a full FIFO is
// accepted only when a read happens in the same cycle.
module haze_sync_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             wr_ok, rd_ok;

   assign level   = wr_ptr_q - rd_ptr_q;
   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
   assign rd_ok   = rd_en && !empty;
   assign wr_ok   = wr_en && (!full || rd_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (wr_ok) begin
         mem_d[wr_ptr_q[AW-1:0]] = wr_data;
         wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/haze_out_stream.sv
// Buffers haze-core pixels and streams them with frame/line markers over a
// valid/ready link. Define PIXEL_CHECKSUM_EN to add the per-frame checksum port.
module haze_out_stream
   import haze_pkg::*;
#(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512,
   parameter int FIFO_DEPTH = 64
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [PIXEL_W-1:0]              output_pixel,
   input  logic                            output_is_valid,
   output logic [PIXEL_W-1:0]              m_pixel,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic                            m_sof,
   output logic                            m_eol,
   output logic                            m_eof,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            overflow,
`ifdef PIXEL_CHECKSUM_EN
   output logic                            frame_done,
   output logic [31:0]                     checksum
`else
   output logic                            frame_done
`endif
);

   localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   logic [PIXEL_W-1:0] fifo_rd_data;
   logic               fifo_full, fifo_empty;
   logic               push, pop, drop, xfer;
   logic               last_col, last_row;

   logic [PIXEL_W-1:0] m_pixel_q, m_pixel_d;
   logic               m_valid_q, m_valid_d;
   logic               overflow_q, overflow_d;
   logic               frame_done_q, frame_done_d;
   logic [CW-1:0]      col_q, col_d;
   logic [RW-1:0]      row_q, row_d;
   state_t             state_q, state_d;

   assign xfer = m_valid_q && m_ready;
   assign pop  = !fifo_empty && (!m_valid_q || m_ready);
   assign push = output_is_valid && (!fifo_full || pop);
   assign drop = output_is_valid && fifo_full && !pop;

   haze_sync_fifo #(
      .WIDTH (PIXEL_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (output_pixel),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Counters point at the pixel held in the output register, so the flags
   // stay stable across a stall without extra registers.
   assign last_col   = (col_q == CW'(IMG_WIDTH - 1));
   assign last_row   = (row_q == RW'(IMG_HEIGHT - 1));
   assign m_sof      = m_valid_q && (col_q == '0) && (row_q == '0);
   assign m_eol      = m_valid_q && last_col;
   assign m_eof      = m_eol && last_row;
   assign m_pixel    = m_pixel_q;
   assign m_valid    = m_valid_q;
   assign overflow   = overflow_q;
   assign frame_done = frame_done_q;

   always_comb begin
      m_pixel_d  = m_pixel_q;
      m_valid_d  = m_valid_q;
      overflow_d = overflow_q | drop;
      col_d      = col_q;
      row_d      = row_q;
      if (pop) begin
         m_pixel_d = fifo_rd_data;
         m_valid_d = 1'b1;
      end else if (xfer) begin
         m_valid_d = 1'b0;
      end
      if (xfer) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (xfer && !m_eof) state_d = STREAM;
         STREAM:  if (xfer && m_eof)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      frame_done_d = xfer && m_eof;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_pixel_q    <= '0;
         m_valid_q    <= 1'b0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
         col_q        <= '0;
         row_q        <= '0;
         state_q      <= IDLE;
      end else begin
         m_pixel_q    <= m_pixel_d;
         m_valid_q    <= m_valid_d;
         overflow_q   <= overflow_d;
         frame_done_q <= frame_done_d;
         col_q        <= col_d;
         row_q        <= row_d;
         state_q      <= state_d;
      end
   end

`ifdef PIXEL_CHECKSUM_EN
   logic [31:0] sum_q, sum_d;
   logic [31:0] frame_sum_q, frame_sum_d;

   always_comb begin
      sum_d       = sum_q;
      frame_sum_d = frame_sum_q;
      if (xfer) begin
         if (m_eof) begin
            frame_sum_d = sum_q + {8'd0, m_pixel_q};
            sum_d       = '0;
         end else begin
            sum_d = sum_q + {8'd0, m_pixel_q};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q       <= '0;
         frame_sum_q <= '0;
      end else begin
         sum_q       <= sum_d;
         frame_sum_q <= frame_sum_d;
      end
   end

   assign checksum = frame_sum_q;
`endif

endmodule

// File: doc/haze_out_stream.md
HAZE_OUT_STREAM -- requirements
Module: haze_out_stream

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 512, pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 512, lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 64, buffer entries; power of two, at least 4.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port output_pixel  in  24  processed pixel from the haze-removal core, {R,G,B}, B in [7:0].
REQ-007 SHALL have port output_is_valid  in  1  pixel qualifier; there is no backpressure toward the core.
REQ-008 SHALL have port m_pixel  out  24  streamed pixel.
REQ-009 SHALL have port m_valid  out  1  m_pixel holds a pixel.
REQ-010 SHALL have port m_ready  in  1  downstream accepts.
REQ-011 SHALL have port m_sof  out  1  current m_pixel is frame pixel 0.
REQ-012 SHALL have port m_eol  out  1  current m_pixel is the last pixel of its line.
REQ-013 SHALL have port m_eof  out  1  current m_pixel is the last pixel of the frame.
REQ-014 SHALL have port fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries, excluding the output register.
REQ-015 SHALL have port overflow  out  1  sticky flag: a pixel was dropped.
REQ-016 SHALL have port frame_done  out  1  one-cycle pulse on transfer of the m_eof pixel.

Function
REQ-017 SHALL write output_pixel into the FIFO in every cycle where output_is_valid=1 and the FIFO is not full.
REQ-018 SHALL, on output_is_valid=1 with a full FIFO and no pop in the same cycle, drop the pixel, set overflow, and leave the FIFO unchanged.
REQ-019 SHALL accept the write when the FIFO is full and a pop occurs in the same cycle; fifo_level stays unchanged.
REQ-020 SHALL pop into the output register when the FIFO is non-empty and either m_valid=0 or m_ready=1.
REQ-021 SHALL take 2 cycles from input to output: a pixel written in cycle N into an empty FIFO and an empty output register appears with m_valid=1 in cycle N+2.
REQ-022 SHALL transfer a pixel when m_valid=1 and m_ready=1.
REQ-023 SHALL hold m_pixel, m_sof, m_eol and m_eof stable while m_valid=1 and m_ready=0.
REQ-024 SHALL sustain 1 pixel per cycle with m_ready held at 1.
REQ-025 SHALL keep col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) counters that advance on each transfer.
REQ-026 SHALL wrap col to 0 at IMG_WIDTH-1 and increment row.
REQ-027 SHALL wrap row to 0 after the m_eof transfer.
REQ-028 SHALL derive the flags from the counter position of the pixel in the output register:
- m_sof: col=0 and row=0.
- m_eol: col=IMG_WIDTH-1.
- m_eof: m_eol=1 and row=IMG_HEIGHT-1.
REQ-029 SHALL sequence the frame with FSM IDLE -> STREAM -> IDLE:
- IDLE -> STREAM on the first transfer.
- STREAM -> IDLE on the m_eof transfer, with frame_done=1 in the following cycle.
REQ-030 SHALL keep the counters frame-aligned when pixels are dropped; the drop is visible only through overflow.

Reset
REQ-031 SHALL, while rst=1, return to the reset state:
- m_valid=0, m_pixel=0, all flags=0, frame_done=0, overflow=0, fifo_level=0.
- FIFO pointers 0, counters 0, FSM=IDLE.
REQ-032 SHALL, on rst asserted mid-frame, discard buffered pixels with no frame_done; the next transfer is marked m_sof.

Configuration
REQ-033 SHALL, when PIXEL_CHECKSUM_EN is defined, add output port checksum (32 bits), which is the sum modulo 2^32 of every transferred m_pixel zero-extended, and register it as frame_checksum on the m_eof transfer.
REQ-034 SHALL clear the running checksum after the m_eof transfer.
REQ-035 SHALL reset the checksum and frame_checksum to 0 while rst=1.
REQ-036 SHALL, when PIXEL_CHECKSUM_EN is undefined, have no checksum port and no checksum logic.

Structure
REQ-037 SHALL place the FSM state typedef (IDLE, STREAM) and PIXEL_W=24 in shared package haze_pkg.
REQ-038 SHALL implement the buffer as sub-module haze_sync_fifo: parameterised width and depth, full, empty and level outputs.

Verification
REQ-039 SHALL verify a 4x2 frame with m_ready=1 and 8 consecutive pixels 0x000001..0x000008: outputs in order, first output 2 cycles after the first input, m_sof on 0x000001, m_eol on 0x000004 and 0x000008, m_eof and frame_done tied to 0x000008.
REQ-040 SHALL verify with FIFO_DEPTH=4 and m_ready=0: 6 pixels give fifo_level=4, m_valid=1 holding pixel 1, overflow=1, and only pixels 1..5 delivered after m_ready=1.
REQ-041 SHALL verify with the FIFO full: a simultaneous write and pop keeps fifo_level=4 and leaves overflow=0.
REQ-042 SHALL verify that random m_ready toggling across two back-to-back 4x2 frames gives data-order integrity, two frame_done pulses, and m_sof on pixel 9.
REQ-043 SHALL verify that rst after 3 of 8 pixels, then a fresh frame, gives m_sof on the first new pixel and no frame_done from the aborted frame.
REQ-044 SHALL verify with PIXEL_CHECKSUM_EN and pixels 0xFFFFFF x8: frame_checksum=0x07FFFFF8.
